if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage directly downstream of the PC register. Each cycle it presents the held PC to instruction memory through a valid/ready request channel and captures the returned instruction. Fetched {pc, instr} pairs are buffered in a 2-entry queue for decode. It also drives the PC register's load enable and next value, covering both sequential PC+4 advance and branch/jump redirect.

## Interface
- SIZE, 64, PC/address width
- INSTR_W, 32, instruction width
- RESET_PC, 0, PC value loaded during reset
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- pc_in  in  SIZE  current PC, from the PC register output
- pc_next  out  SIZE  next PC, to the PC register input
- pc_en  out  1  PC register load enable
- redirect  in  1  branch/jump taken; one-cycle pulse
- redirect_pc  in  SIZE  redirect target
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  SIZE  fetch address; combinationally equal to pc_in
- imem_resp_valid  in  1  response valid; one cycle; arrives at least 1 cycle after acceptance
- imem_resp_data  in  INSTR_W  fetched instruction
- id_valid  out  1  queue head valid
- id_ready  in  1  decode consumes head
- id_pc  out  SIZE  PC of head entry
- id_instr  out  INSTR_W  instruction of head entry

## Operation
- The FSM has three states:
  - REQ: issue a request.
  - WAIT: one request outstanding.
  - DRAIN: one request outstanding, and its response is to be discarded.
- At most one request is outstanding at any time.
- Queue: 2 entries, count 0..2.
  - id_valid = (count != 0).
  - Pop on id_valid && id_ready.
  - Simultaneous push and pop leaves count unchanged.
- imem_req_valid = (state == REQ) && (count < 2).
  - The address may change while valid is high (after a redirect); memory samples only on handshake.
- PC control, in priority order:
  - rst: pc_en = 1, pc_next = RESET_PC.
  - redirect: pc_en = 1, pc_next = redirect_pc.
  - Request handshake: pc_en = 1, pc_next = pc_in + 4, modulo 2^SIZE (wraps).
  - Otherwise: pc_en = 0, and pc_next = pc_in.
- On handshake, req_pc latches pc_in.
- Transitions:
  - REQ: on handshake without redirect, go to WAIT. On handshake with redirect, go to DRAIN.
  - WAIT: on response without redirect, push {req_pc, imem_resp_data} and go to REQ. On response with redirect, discard and go to REQ. On redirect without response, go to DRAIN.
  - DRAIN: on response, discard and go to REQ. A redirect in DRAIN stays in DRAIN; the PC is still updated.
- Redirect flushes the queue: count becomes 0 on that edge.
  - A pop in the same cycle is ignored.
  - A push in the same cycle is dropped.
- The queue never overflows.
  - A request is issued only with count < 2, and count cannot rise while a request is outstanding.
- Reset values: state = REQ, count = 0, req_pc = 0.
  - Resulting outputs: id_valid = 0, imem_req_valid = 0 during rst, id_pc = 0, id_instr = 0.
  - Queue storage is cleared.
- Reset mid-operation: the outstanding request is abandoned. A response arriving after reset deasserts while in REQ is ignored.

## Timing
- PC register update: RESET_PC loads at the rst edge; pc_in = RESET_PC in the first cycle after rst deasserts, and the first request is issued that cycle.
- Minimum fetch-to-decode latency: handshake in cycle N, response N+1, id_valid at N+2.
- Peak throughput: one instruction per 2 cycles (REQ→WAIT→REQ).
- pc_en, pc_next and imem_req_valid are combinational from state, count, rst and redirect.
  - No combinational path from imem_resp_* or id_ready to any output.
- Redirect takes effect in one cycle: the first request to redirect_pc can issue the cycle after the redirect if the FSM is in REQ or returns to REQ.

## Test plan
- Reset, then memory with ready = 1, 1-cycle latency, id_ready = 1 → pc_en pulses at handshakes; imem_addr sequence 0x0, 0x4, 0x8; id_pc 0x0, 0x4, 0x8 with matching instr, each 2 cycles apart.
- id_ready = 0 → queue fills with 0x0 and 0x4; imem_req_valid falls and pc_in holds at 0x8. Raise id_ready → entries drain in order, and fetch of 0x8 resumes.
- imem_req_ready low for 5 cycles → request held, pc_en = 0 throughout, imem_addr stable at 0x8.
- Redirect to 0x100 while in WAIT (fetch of 0x8 outstanding) with 3-cycle latency → queue flushed; the 0x8 response is discarded; next id_pc = 0x100.
- Redirect to 0x200 coincident with a handshake → FSM goes to DRAIN; the stale response is dropped; first delivered id_pc = 0x200. Also cover PC = 2^64−4 → pc_next wraps to 0x0.
- rst asserted in WAIT, then response arrives 1 cycle after rst deasserts → response ignored, id_valid stays 0, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: issues one outstanding imem request at a time, drives the
// PC register (sequential advance or redirect), and buffers fetched {pc, instr} in a 2-entry queue.
module if_fetch #(
    parameter int              SIZE     = 64,
    parameter int              INSTR_W  = 32,
    parameter logic [SIZE-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SIZE-1:0]    pc_in,
    output logic [SIZE-1:0]    pc_next,
    output logic               pc_en,
    input  logic               redirect,
    input  logic [SIZE-1:0]    redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [SIZE-1:0]    imem_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [SIZE-1:0]    id_pc,
    output logic [INSTR_W-1:0] id_instr
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [1:0]      count_reg, count_next;
    logic            rd_ptr_reg, rd_ptr_next;
    logic            wr_ptr_reg, wr_ptr_next;
    logic [SIZE-1:0] req_pc_reg;

    logic handshake;
    logic push;
    logic pop;

    logic [SIZE-1:0]    entry_pc    [2];
    logic [INSTR_W-1:0] entry_instr [2];

    assign imem_addr      = pc_in;
    assign imem_req_valid = !rst && (state_reg == S_REQ) && (count_reg != 2'd2);
    assign handshake      = imem_req_valid && imem_req_ready;

    // A redirect in the same cycle kills both the incoming entry and any pop.
    assign push = (state_reg == S_WAIT) && imem_resp_valid && !redirect;
    assign pop  = (count_reg != 2'd0) && id_ready && !redirect;

    assign id_valid = (count_reg != 2'd0);
    assign id_pc    = entry_pc[rd_ptr_reg];
    assign id_instr = entry_instr[rd_ptr_reg];

    always_comb begin
        pc_en   = 1'b0;
        pc_next = pc_in;
        if (rst) begin
            pc_en   = 1'b1;
            pc_next = RESET_PC;
        end else if (redirect) begin
            pc_en   = 1'b1;
            pc_next = redirect_pc;
        end else if (handshake) begin
            pc_en   = 1'b1;
            pc_next = pc_in + SIZE'(4);
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_REQ: begin
                if (handshake) begin
                    state_next = redirect ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    state_next = S_REQ;
                end else if (redirect) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_resp_valid) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    always_comb begin
        count_next  = count_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        unique case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
        if (push) begin
            wr_ptr_next = ~wr_ptr_reg;
        end
        if (pop) begin
            rd_ptr_next = ~rd_ptr_reg;
        end
        if (redirect) begin
            count_next  = 2'd0;
            rd_ptr_next = 1'b0;
            wr_ptr_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_REQ;
            count_reg  <= 2'd0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            req_pc_reg <= '0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            if (handshake) begin
                req_pc_reg <= pc_in;
            end
        end
    end

    // Queue storage; each slot is written only when the write pointer selects it.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [SIZE-1:0]    entry_pc_reg;
            logic [INSTR_W-1:0] entry_instr_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_pc_reg    <= '0;
                    entry_instr_reg <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    entry_pc_reg    <= req_pc_reg;
                    entry_instr_reg <= imem_resp_data;
                end
            end

            assign entry_pc[gi]    = entry_pc_reg;
            assign entry_instr[gi] = entry_instr_reg;
        end
    endgenerate

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: PC register and latency-programmable memory around the DUT,
// a transaction-level model checked every cycle, and directed phases with literal expectations.
module tb_if_fetch;

    localparam int SIZE    = 64;
    localparam int INSTR_W = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic [SIZE-1:0]    pc_reg = 64'h0000_0000_0000_ABC0;
    logic [SIZE-1:0]    pc_next;
    logic               pc_en;
    logic               redirect;
    logic [SIZE-1:0]    redirect_pc;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [SIZE-1:0]    imem_addr;
    logic               imem_resp_valid = 1'b0;
    logic [INSTR_W-1:0] imem_resp_data  = '0;
    logic               id_valid;
    logic               id_ready;
    logic [SIZE-1:0]    id_pc;
    logic [INSTR_W-1:0] id_instr;

    if_fetch #(.SIZE(SIZE), .INSTR_W(INSTR_W), .RESET_PC('0)) dut (
        .clk(clk), .rst(rst),
        .pc_in(pc_reg), .pc_next(pc_next), .pc_en(pc_en),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_instr(id_instr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit checking = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pc_en) pc_reg <= pc_next;
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    // Memory: accepts on handshake, answers mem_lat cycles later with a one-cycle pulse.
    int              mem_lat = 1;
    int              mem_cnt = 0;
    logic [SIZE-1:0] mem_addr = '0;
    logic [SIZE-1:0] hs_log [$];

    initial begin
        forever begin
            @(negedge clk);
            if (imem_req_valid === 1'b1 && imem_req_ready) begin
                mem_cnt  = mem_lat;
                mem_addr = imem_addr;
                hs_log.push_back(imem_addr);
                $display("req     addr=%h", imem_addr);
            end
            @(posedge clk);
            #1;
            imem_resp_valid = 1'b0;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = instr_of(mem_addr);
                end
            end
        end
    end

    // Transaction model: one outstanding request (possibly marked stale) and a list of fetched entries.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t          q [$];
    bit              m_out     = 1'b0;
    bit              m_discard = 1'b0;
    logic [SIZE-1:0] m_req_pc  = '0;
    bit              exp_rv, exp_hs, exp_en, got;
    logic [SIZE-1:0] exp_next;

    logic [SIZE-1:0]    deliv_pc    [$];
    logic [INSTR_W-1:0] deliv_instr [$];
    int                 deliv_cyc   [$];

    always @(negedge clk) begin
        if (checking) begin
            exp_rv = !rst && !m_out && (q.size() < 2);
            exp_hs = exp_rv && imem_req_ready;
            if (rst) begin
                exp_en = 1'b1; exp_next = '0;
            end else if (redirect) begin
                exp_en = 1'b1; exp_next = redirect_pc;
            end else if (exp_hs) begin
                exp_en = 1'b1; exp_next = pc_reg + 64'd4;
            end else begin
                exp_en = 1'b0; exp_next = pc_reg;
            end
            check("req_valid", imem_req_valid, exp_rv);
            check("pc_en", pc_en, exp_en);
            check("pc_next", pc_next, exp_next);
            check("imem_addr", imem_addr, pc_reg);
            check("id_valid", id_valid, q.size() != 0);
            if (q.size() != 0) begin
                check("id_pc", id_pc, q[0].pc);
                check("id_instr", id_instr, q[0].instr);
            end

            if (!rst && id_valid === 1'b1 && id_ready && !redirect) begin
                deliv_pc.push_back(id_pc);
                deliv_instr.push_back(id_instr);
                deliv_cyc.push_back(cyc);
                $display("deliver pc=%h instr=%h", id_pc, id_instr);
            end

            if (rst) begin
                m_out = 1'b0; m_discard = 1'b0; q.delete();
            end else begin
                got = m_out && imem_resp_valid;
                if (q.size() != 0 && id_ready && !redirect) void'(q.pop_front());
                if (got && !m_discard && !redirect) q.push_back({m_req_pc, imem_resp_data});
                if (redirect) q.delete();
                if (got) begin
                    m_out = 1'b0; m_discard = 1'b0;
                end else if (m_out && redirect) begin
                    m_discard = 1'b1;
                end
                if (exp_hs) begin
                    m_out = 1'b1; m_req_pc = pc_reg; m_discard = redirect;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_deliv(input int n);
        int t;
        t = 0;
        while (deliv_pc.size() < n && t < 300) begin
            mid();
            t++;
        end
        if (deliv_pc.size() < n) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_deliv: got %0d deliveries, required %0d", deliv_pc.size(), n);
        end
    endtask

    task automatic wait_hs(input int n);
        int t;
        t = 0;
        while (hs_log.size() < n && t < 300) begin
            mid();
            t++;
        end
        if (hs_log.size() < n) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_hs: got %0d requests, required %0d", hs_log.size(), n);
        end
    endtask

    int p_cyc, base, t;

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1; id_ready = 1'b1;
        step();
        checking = 1'b1;
        step();
        mid();
        check("rst req_valid", imem_req_valid, 1'b0);
        check("rst pc_en", pc_en, 1'b1);
        check("rst pc_next", pc_next, 64'h0);

        // Streaming: 0x0, 0x4, 0x8 delivered two cycles apart.
        step(); rst = 1'b0;
        mid();
        p_cyc = cyc;
        check("post-rst id_valid", id_valid, 1'b0);
        check("post-rst id_pc", id_pc, 64'h0);
        check("post-rst id_instr", id_instr, 32'h0);
        check("post-rst addr", imem_addr, 64'h0);
        check("post-rst req_valid", imem_req_valid, 1'b1);
        wait_deliv(3);
        check("stream pc0", deliv_pc[0], 64'h0);
        check("stream pc1", deliv_pc[1], 64'h4);
        check("stream pc2", deliv_pc[2], 64'h8);
        check("stream instr0", deliv_instr[0], 32'h1357_9BDF);
        check("stream instr1", deliv_instr[1], 32'h1357_9BDB);
        check("stream instr2", deliv_instr[2], 32'h1357_9BD7);
        check("first latency", deliv_cyc[0] - p_cyc, 2);
        check("spacing 1", deliv_cyc[1] - deliv_cyc[0], 2);
        check("spacing 2", deliv_cyc[2] - deliv_cyc[1], 2);
        check("hs addr 2", hs_log[2], 64'h8);

        // Backpressure from decode: queue fills with 0x0 and 0x4, PC holds at 0x8.
        step(); rst = 1'b1; id_ready = 1'b0;
        step();
        deliv_pc.delete(); deliv_instr.delete(); deliv_cyc.delete(); hs_log.delete();
        step(); rst = 1'b0;
        repeat (6) mid();
        check("full req_valid", imem_req_valid, 1'b0);
        check("full pc_in", pc_reg, 64'h8);
        check("full id_pc", id_pc, 64'h0);
        check("full requests", hs_log.size(), 2);

        // Memory stalls for 5 cycles while decode drains the queue.
        step(); imem_req_ready = 1'b0; id_ready = 1'b1; mem_lat = 3;
        for (int i = 0; i < 5; i++) begin
            mid();
            check("stall pc_en", pc_en, 1'b0);
            check("stall addr", imem_addr, 64'h8);
        end
        check("stall req_valid", imem_req_valid, 1'b1);
        check("drain pc0", deliv_pc[0], 64'h0);
        check("drain pc1", deliv_pc[1], 64'h4);
        step(); imem_req_ready = 1'b1;

        // Redirect while the 0x8 fetch is outstanding (3-cycle latency).
        step(); redirect = 1'b1; redirect_pc = 64'h100;
        mid();
        check("redir pc_en", pc_en, 1'b1);
        check("redir pc_next", pc_next, 64'h100);
        step(); redirect = 1'b0;
        wait_deliv(3);
        check("after redir pc", deliv_pc[2], 64'h100);
        check("after redir instr", deliv_instr[2], 32'h1357_9ADF);
        check("hs after redir", hs_log[hs_log.size() - 1] == 64'h8 ? 64'h8 : hs_log[3], 64'h100);

        // Redirect coincident with a handshake while the queue holds an entry.
        step(); id_ready = 1'b0; imem_req_ready = 1'b0; mem_lat = 2;
        repeat (8) mid();
        check("held id_valid", id_valid, 1'b1);
        check("held id_pc", id_pc, 64'h104);
        check("held addr", imem_addr, 64'h108);
        base = deliv_pc.size();
        step(); imem_req_ready = 1'b1; redirect = 1'b1; redirect_pc = 64'h200;
        mid();
        check("coinc pc_en", pc_en, 1'b1);
        check("coinc pc_next", pc_next, 64'h200);
        step(); redirect = 1'b0; id_ready = 1'b1;
        mid();
        check("flushed id_valid", id_valid, 1'b0);
        wait_deliv(base + 1);
        check("coinc first pc", deliv_pc[base], 64'h200);
        check("coinc first instr", deliv_instr[base], 32'h1357_99DF);

        // Redirect while draining, to the top of the address space; PC must wrap.
        step(); imem_req_ready = 1'b0;
        repeat (6) mid();
        base = deliv_pc.size();
        step(); imem_req_ready = 1'b1; redirect = 1'b1; redirect_pc = 64'h300; mem_lat = 3;
        step(); redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        mid();
        check("drain redir pc_en", pc_en, 1'b1);
        check("drain redir pc_next", pc_next, 64'hFFFF_FFFF_FFFF_FFFC);
        check("drain req_valid", imem_req_valid, 1'b0);
        step(); redirect = 1'b0;
        wait_deliv(base + 2);
        check("wrap pc top", deliv_pc[base], 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap instr top", deliv_instr[base], 32'hECA8_6423);
        check("wrap pc zero", deliv_pc[base + 1], 64'h0);
        check("wrap instr zero", deliv_instr[base + 1], 32'h1357_9BDF);

        // Reset while a slow fetch is outstanding; its response lands in the first cycle after reset.
        step(); mem_lat = 10;
        base = hs_log.size();
        wait_hs(base + 1);
        step(); rst = 1'b1; mem_lat = 1;
        t = 0;
        while (mem_cnt != 1 && t < 40) begin
            mid();
            t++;
        end
        if (mem_cnt != 1) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_mem: got count %0d, required 1", mem_cnt);
        end
        step(); rst = 1'b0;
        mid();
        check("rst-wait id_valid p0", id_valid, 1'b0);
        check("rst-wait addr", imem_addr, 64'h0);
        check("rst-wait req_valid", imem_req_valid, 1'b1);
        mid();
        check("rst-wait id_valid p1", id_valid, 1'b0);
        mid();
        check("rst-wait id_valid p2", id_valid, 1'b1);
        check("rst-wait id_pc", id_pc, 64'h0);
        check("rst-wait id_instr", id_instr, 32'h1357_9BDF);
        repeat (4) mid();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
